// File: rtl/cpu_mem_arbiter.sv
// rtl/cpu_mem_arbiter.sv - instruction/data channel arbiter onto one shared memory port
//
// Purpose: grants one transaction at a time from the CPU fetch channel or the
// data channel to a single shared memory port. Ties between the channels are
// broken round-robin, and each read response goes back to the channel that
// issued it. conflict_cnt counts IDLE cycles in which both channels request.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   PC, Inst_Req_Valid/Ready        fetch request channel
//   Instruction, Inst_Valid/Ready   fetch response channel
//   Address, MemWrite, MemRead,
//   Write_data, Write_strb,
//   Mem_Req_Ready                   data request channel
//   Read_data, Read_data_Valid/Ready  load response channel
//   m_addr, m_wen, m_wdata, m_wstrb,
//   m_req_valid/ready               shared-port request
//   m_rdata, m_rdata_valid/ready    shared-port read response
//   conflict_cnt                    contention performance counter
module cpu_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   PC,
  input  logic                Inst_Req_Valid,
  output logic                Inst_Req_Ready,
  output logic [DATA_W-1:0]   Instruction,
  output logic                Inst_Valid,
  input  logic                Inst_Ready,
  input  logic [ADDR_W-1:0]   Address,
  input  logic                MemWrite,
  input  logic                MemRead,
  input  logic [DATA_W-1:0]   Write_data,
  input  logic [DATA_W/8-1:0] Write_strb,
  output logic                Mem_Req_Ready,
  output logic [DATA_W-1:0]   Read_data,
  output logic                Read_data_Valid,
  input  logic                Read_data_Ready,
  output logic [ADDR_W-1:0]   m_addr,
  output logic                m_wen,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_req_valid,
  input  logic                m_req_ready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_rdata_valid,
  output logic                m_rdata_ready,
  output logic [31:0]         conflict_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_REQ  = 3'b010,
    S_RESP = 3'b100
  } state_t;

  // Channel encoding for owner/last: 0 = instruction fetch, 1 = data.
  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_owner;
  logic        w_owner_nxt;
  logic        r_last;
  logic        w_last_nxt;
  logic [31:0] r_conflict_cnt;

  logic w_i_req;
  logic w_d_req;
  logic w_grant_data;
  logic w_conflict;

  assign w_i_req    = Inst_Req_Valid;
  assign w_d_req    = MemRead | MemWrite;
  assign w_conflict = (r_state == S_IDLE) && w_i_req && w_d_req;

  // Data wins when alone, or on a tie when fetch was the last channel granted.
  assign w_grant_data = w_d_req & (~w_i_req | ~r_last);

  assign conflict_cnt = r_conflict_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_owner        <= 1'b0;
      r_last         <= 1'b0;
      r_conflict_cnt <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      // Free-running wrap at 2^32 is intended.
      if (w_conflict) begin
        r_conflict_cnt <= r_conflict_cnt + 32'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_owner_nxt     = r_owner;
    w_last_nxt      = r_last;
    Inst_Req_Ready  = 1'b0;
    Mem_Req_Ready   = 1'b0;
    Inst_Valid      = 1'b0;
    Read_data_Valid = 1'b0;
    m_req_valid     = 1'b0;
    m_wen           = 1'b0;
    m_wstrb         = '0;
    m_rdata_ready   = 1'b0;
    // Payload is not latched: the owner holds it stable until accepted.
    m_addr          = r_owner ? Address : PC;
    m_wdata         = r_owner ? Write_data : '0;
    // Both response buses mirror the shared read data; only Valid qualifies them.
    Instruction     = m_rdata;
    Read_data       = m_rdata;

    case (r_state)
      S_IDLE: begin
        if (w_i_req || w_d_req) begin
          w_owner_nxt = w_grant_data;
          w_last_nxt  = w_grant_data;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        m_req_valid    = 1'b1;
        m_wen          = r_owner & MemWrite;
        m_wstrb        = r_owner ? Write_strb : '0;
        Inst_Req_Ready = ~r_owner & m_req_ready;
        Mem_Req_Ready  = r_owner & m_req_ready;
        if (m_req_ready) begin
          // Writes carry no response phase.
          w_state_nxt = (r_owner && MemWrite) ? S_IDLE : S_RESP;
        end
      end
      S_RESP: begin
        Inst_Valid      = ~r_owner & m_rdata_valid;
        Read_data_Valid = r_owner & m_rdata_valid;
        m_rdata_ready   = r_owner ? Read_data_Ready : Inst_Ready;
        if (m_rdata_valid && m_rdata_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
